// File: rtl/psram_ui_pkg.sv
// Shared definitions for the PSRAM user-interface responder: command encodings,
// burst geometry, default timing and the controller state type.
package psram_ui_pkg;

  localparam logic CMD_WRITE   = 1'b1;
  localparam logic CMD_READ    = 1'b0;
  localparam int   BURST_BEATS = 4;
  localparam int   TCMD_DEF    = 14;
  localparam int   RD_LAT_DEF  = 18;
  localparam int   CNT_W       = 6;

  typedef enum logic [2:0] {
    CALIB,
    IDLE,
    WRITE,
    READ,
    RECOVER
  } state_t;

endpackage

// File: rtl/psram_ui_responder_if.sv
// User-side command/data bundle between user logic (master) and the PSRAM
// responder (slave).
interface psram_ui_responder_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 64
);

  logic                    cmd_en;
  logic                    cmd;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] data_mask;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_data_valid;
  logic                    init_calib;
  logic                    cmd_err;

  modport master (
    output cmd_en, cmd, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid, init_calib, cmd_err
  );

  modport slave (
    input  cmd_en, cmd, addr, wr_data, data_mask,
    output rd_data, rd_data_valid, init_calib, cmd_err
  );

endinterface

// File: rtl/psram_emu_mem.sv
// Single-clock block RAM backing the emulated PSRAM: per-byte write enables and
// a registered read port (data appears one cycle after ren).
module psram_emu_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 10
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [MEM_AW-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    ren,
  input  logic [MEM_AW-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]   q
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (ren) q <= mem[raddr];
  end

endmodule

// File: rtl/psram_ui_responder.sv
// PSRAM user-interface responder: calibration delay, 4-beat write/read bursts
// into on-chip RAM, command spacing and fixed read latency.
module psram_ui_responder #(
  parameter int ADDR_WIDTH  = 21,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_BEATS = psram_ui_pkg::BURST_BEATS,
  parameter int MEM_AW      = 10,
  parameter int CALIB_DELAY = 64,
  parameter int TCMD        = psram_ui_pkg::TCMD_DEF,
  parameter int RD_LAT      = psram_ui_pkg::RD_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  psram_ui_responder_if.slave   ui
);

  import psram_ui_pkg::*;

  localparam int NB     = DATA_WIDTH / 8;
  localparam int RD_END = (TCMD > RD_LAT + BURST_BEATS) ? TCMD : RD_LAT + BURST_BEATS;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [MEM_AW-1:0]       base;
  logic                    init_calib_q;
  logic                    cmd_err_q;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  logic                    accept;
  logic                    wr_beat;
  logic [MEM_AW-1:0]       idx_in;
  logic [MEM_AW-1:0]       waddr;
  logic [MEM_AW-1:0]       raddr;
  logic [NB-1:0]           be;
  logic                    ren;
  logic                    rd_vld_nxt;
  logic [CNT_W-1:0]        rd_beat;
  logic [DATA_WIDTH-1:0]   mem_q;
  logic                    unused_addr;

  assign idx_in      = ui.addr[MEM_AW+1:2];
  assign unused_addr = ^{ui.addr[ADDR_WIDTH-1:MEM_AW+2], ui.addr[1:0]};
  assign accept      = (state == IDLE) && ui.cmd_en;

  // Beat 0 of a write lands on the accept edge; beats 1..3 follow using the counter as offset.
  assign wr_beat = (accept && ui.cmd == CMD_WRITE) || (state == WRITE);
  assign waddr   = accept ? idx_in : base + MEM_AW'(cnt);
  assign be      = wr_beat ? ~ui.data_mask : '0;

  // RAM read is issued one cycle ahead so the registered output lines up at RD_LAT+k.
  assign rd_beat    = cnt - CNT_W'(RD_LAT - 1);
  assign ren        = (state == READ) && (cnt >= CNT_W'(RD_LAT - 1))
                      && (cnt < CNT_W'(RD_LAT - 1 + BURST_BEATS));
  assign raddr      = base + MEM_AW'(rd_beat);
  assign rd_vld_nxt = (state == READ) && (cnt >= CNT_W'(RD_LAT))
                      && (cnt < CNT_W'(RD_LAT + BURST_BEATS));

  psram_emu_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_AW     (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .be    (be),
    .waddr (waddr),
    .wdata (ui.wr_data),
    .ren   (ren),
    .raddr (raddr),
    .q     (mem_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CALIB;
      cnt          <= '0;
      base         <= '0;
      init_calib_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      cmd_err_q  <= ui.cmd_en && (state != IDLE);
      rd_valid_q <= rd_vld_nxt;
      rd_data_q  <= rd_vld_nxt ? mem_q : '0;
      case (state)
        CALIB: begin
          if (cnt == CNT_W'(CALIB_DELAY - 1)) begin
            init_calib_q <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (ui.cmd_en) begin
            base  <= idx_in;
            cnt   <= CNT_W'(1);
            state <= (ui.cmd == CMD_WRITE) ? WRITE : READ;
          end
        end
        WRITE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(BURST_BEATS - 1)) state <= RECOVER;
        end
        RECOVER: begin
          if (cnt == CNT_W'(TCMD - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READ: begin
          if (cnt == CNT_W'(RD_END - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= CALIB;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign ui.rd_data       = rd_data_q;
  assign ui.rd_data_valid = rd_valid_q;
  assign ui.init_calib    = init_calib_q;
  assign ui.cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_psram_ui_responder.sv
// Scoreboard bench for psram_ui_responder: expected read beats are queued when a
// read is issued and popped as rd_data_valid beats arrive.
module tb_psram_ui_responder;

  import psram_ui_pkg::*;

  localparam int AW     = 21;
  localparam int DW     = 64;
  localparam int MAW    = 10;
  localparam int NWORDS = 1 << MAW;
  localparam int CAL    = 64;
  localparam int TC     = 14;
  localparam int RL     = 18;
  localparam int BB     = 4;
  localparam int RD_END = 22;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psram_ui_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ui ();

  psram_ui_responder #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .BURST_BEATS (BB),
    .MEM_AW      (MAW),
    .CALIB_DELAY (CAL),
    .TCMD        (TC),
    .RD_LAT      (RL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ui    (ui)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model [NWORDS];
  logic [63:0] exp_q [$];

  always @(negedge clk) begin
    if (ui.rd_data_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got rd_data=%h with no beat expected", ui.rd_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (ui.rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_beat: got %h expected %h", ui.rd_data, e);
        end
      end
    end else begin
      n_checks++;
      if (ui.rd_data !== 64'h0) begin
        n_fail++;
        $display("FAIL rd_data_idle: got %h expected 0", ui.rd_data);
      end
    end
  end

  task automatic idle_inputs();
    ui.cmd_en    = 1'b0;
    ui.cmd       = 1'b0;
    ui.addr      = AW'($urandom);
    ui.wr_data   = {$urandom, $urandom};
    ui.data_mask = 8'($urandom);
  endtask

  // Releases reset at the current negedge and walks the calibration window.
  task automatic do_calib(input int err_at);
    rst_n = 1'b1;
    for (int i = 1; i <= CAL; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i == err_at) begin
        ui.cmd_en    = 1'b1;
        ui.cmd       = CMD_WRITE;
        ui.addr      = '0;
        ui.data_mask = '0;
      end
      n_checks++;
      if (ui.cmd_err !== (err_at != 0 && i == err_at + 1)) begin
        n_fail++;
        $display("FAIL calib_cmd_err: cycle %0d got %b", i, ui.cmd_err);
      end
      if (i == CAL - 1) begin
        n_checks++;
        if (ui.init_calib !== 1'b0) begin
          n_fail++;
          $display("FAIL init_calib_early: cycle %0d got %b expected 0", i, ui.init_calib);
        end
      end
      if (i == CAL) begin
        n_checks++;
        if (ui.init_calib !== 1'b1) begin
          n_fail++;
          $display("FAIL init_calib_late: cycle %0d got %b expected 1", i, ui.init_calib);
        end
      end
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [255:0] d, input logic [31:0] m,
                          input int err_at, input int abort_at);
    int nb;
    int idx;
    ui.cmd_en    = 1'b1;
    ui.cmd       = CMD_WRITE;
    ui.addr      = addr;
    ui.wr_data   = d[63:0];
    ui.data_mask = m[7:0];
    nb = BB;
    for (int i = 1; i <= TC; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst_n = 1'b0;
        idle_inputs();
        nb = abort_at;
        break;
      end
      idle_inputs();
      if (i < BB) begin
        ui.wr_data   = d[i*64 +: 64];
        ui.data_mask = m[i*8 +: 8];
      end
      if (err_at != 0 && i == err_at) begin
        ui.cmd_en    = 1'b1;
        ui.cmd       = CMD_WRITE;
        ui.addr      = '0;
        ui.data_mask = '0;
      end
      n_checks++;
      if (ui.cmd_err !== (err_at != 0 && i == err_at + 1)) begin
        n_fail++;
        $display("FAIL write_cmd_err: cycle %0d got %b", i, ui.cmd_err);
      end
    end
    idx = int'(addr[MAW+1:2]);
    for (int k = 0; k < nb; k++) begin
      for (int b = 0; b < 8; b++) begin
        if (!m[k*8 + b]) model[(idx + k) % NWORDS][b*8 +: 8] = d[k*64 + b*8 +: 8];
      end
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input bit use_exp, input logic [255:0] e);
    int idx;
    int first;
    int nvld;
    idx = int'(addr[MAW+1:2]);
    for (int k = 0; k < BB; k++) exp_q.push_back(use_exp ? e[k*64 +: 64] : model[(idx + k) % NWORDS]);
    ui.cmd_en = 1'b1;
    ui.cmd    = CMD_READ;
    ui.addr   = addr;
    first = -1;
    nvld  = 0;
    for (int i = 1; i <= RD_END; i++) begin
      @(negedge clk);
      idle_inputs();
      if (ui.rd_data_valid) begin
        if (first < 0) first = i - 1;
        nvld++;
      end
    end
    n_checks++;
    if (first != RL) begin
      n_fail++;
      $display("FAIL read_latency: first valid at %0d expected %0d", first, RL);
    end
    n_checks++;
    if (nvld != BB) begin
      n_fail++;
      $display("FAIL read_beats: got %0d valid beats expected %0d", nvld, BB);
    end
  endtask

  task automatic check_reset_outputs();
    n_checks++;
    if (ui.rd_data_valid !== 1'b0 || ui.init_calib !== 1'b0 || ui.cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b calib=%b err=%b expected 0 0 0",
               ui.rd_data_valid, ui.init_calib, ui.cmd_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    do_calib(0);
  endtask

  task automatic test_write_read_basic();
    do_write({9'h1AB, 10'd0, 2'b11},
             {64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 64'h5555_AAAA_5555_AAAA,
              64'hDEAD_BEEF_CAFE_0093},
             {8'hFF, 8'hFF, 8'hFF, 8'hFE}, 0, 0);
    do_read(21'd0, 1'b1, {64'h0, 64'h0, 64'h0, 64'h93});
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a;
    a = AW'((NWORDS - 2) * 4);
    do_write(a, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 32'h0, 0, 0);
    do_read(a, 1'b1, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    do_read(21'd1, 1'b1, {64'h0, 64'h0, 64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333});
  endtask

  task automatic test_cmd_err();
    do_write(21'd64, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             $urandom, 5, 0);
    do_read(21'd64, 1'b0, '0);
    do_read(21'd0, 1'b0, '0);
  endtask

  task automatic test_reset_mid_burst();
    do_write(21'd400, {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                       64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000}, 32'h0, 0, 0);
    do_write(21'd400, {64'hB3B3_B3B3_1111_0003, 64'hB2B2_B2B2_1111_0002,
                       64'hB1B1_B1B1_1111_0001, 64'hB0B0_B0B0_1111_0000}, 32'h0, 0, 2);
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    do_calib(10);
    do_read(21'd400, 1'b0, '0);
    do_read(21'd0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    do_write(21'd800, {64'h0000_0000_0000_0803, 64'h0000_0000_0000_0802,
                       64'h0000_0000_0000_0801, 64'h0000_0000_0000_0800}, 32'h0, 0, 0);
    do_write(21'd816, {64'h0000_0000_0000_0807, 64'h0000_0000_0000_0806,
                       64'h0000_0000_0000_0805, 64'h0000_0000_0000_0804}, 32'h0, 0, 0);
    do_read(21'd800, 1'b0, '0);
    do_read(21'd816, 1'b0, '0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL beats_lost: %0d expected beats never arrived", exp_q.size());
    end
  endtask

  initial begin
    for (int w = 0; w < NWORDS; w++) model[w] = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_write_read_basic();
    test_wrap();
    test_cmd_err();
    test_reset_mid_burst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
